// File: rtl/hub75_panel_driver.sv
// hub75_panel_driver
//   Stores RGB pixels written by the UDP panel writer in a two-bank on-chip
//   framebuffer and scans them out to one 64x64, 1/32-scan HUB75 panel with
//   6-bit binary-coded modulation.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   wr_en        single-cycle pixel write strobe
//   wr_mask      lane enables: [2]=R, [1]=G, [0]=B ([3] ignored)
//   wr_addr      [11:6]=row, [5:0]=column ([15:12] ignored)
//   wr_data      R=[21:16], G=[13:8], B=[5:0] (other bits ignored)
//   hub_r1/g1/b1 top-half (rows 0..31) colour bits
//   hub_r2/g2/b2 bottom-half (rows 32..63) colour bits
//   hub_a        panel row address
//   hub_clk      shift clock
//   hub_lat      latch strobe
//   hub_oe_n     output enable, active low
//   frame_start  one-cycle marker on the first shift cycle of row 0, plane 0
module hub75_panel_driver #(
    parameter int BASE_TIME = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [15:0] wr_addr,
    input  logic [23:0] wr_data,
    output logic        hub_r1,
    output logic        hub_g1,
    output logic        hub_b1,
    output logic        hub_r2,
    output logic        hub_g2,
    output logic        hub_b2,
    output logic [4:0]  hub_a,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic        frame_start
);

    // One counter serves both the 130-clock shift phase and the longest
    // display phase (BASE_TIME << 5).
    localparam int CW         = $clog2(BASE_TIME * 32 + 256);
    localparam int SHIFT_LAST = 129;

    typedef enum logic [1:0] {
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_row;
    logic [2:0]      r_plane;

    logic [5:0] r_top_r [0:2047];
    logic [5:0] r_top_g [0:2047];
    logic [5:0] r_top_b [0:2047];
    logic [5:0] r_bot_r [0:2047];
    logic [5:0] r_bot_g [0:2047];
    logic [5:0] r_bot_b [0:2047];

    logic [7:0]    w_cnt_m1;
    logic [5:0]    w_col;
    logic [10:0]   w_rd_addr;
    logic [10:0]   w_wr_word;
    logic          w_wr_top;
    logic          w_wr_bot;
    logic [CW-1:0] w_disp_len;
    logic [CW-1:0] w_disp_last;
    logic          w_clk_pos;
    logic          w_unused;

    assign w_wr_word = wr_addr[10:0];
    assign w_wr_top  = wr_en && !wr_addr[11];
    assign w_wr_bot  = wr_en &&  wr_addr[11];

    // Shift position c presents column k on cycles 2k+1 and 2k+2 with hub_clk
    // high on 2k+2. The read register is the output register, so the word is
    // fetched one position early: column = (c-1)/2.
    assign w_cnt_m1  = r_cnt[7:0] - 8'd1;
    assign w_col     = w_cnt_m1[6:1];
    assign w_rd_addr = {r_row, w_col};

    assign w_clk_pos = (r_cnt >= CW'(2)) && (r_cnt <= CW'(128)) && !r_cnt[0];

    assign w_disp_len  = CW'(BASE_TIME) << r_plane;
    assign w_disp_last = w_disp_len - CW'(1);

    assign w_unused = &{1'b0, wr_addr[15:12], wr_mask[3], wr_data[23:22],
                        wr_data[15:14], wr_data[7:6], w_cnt_m1[7], w_cnt_m1[0]};

    // Framebuffer writes: per-lane enables, never stalled by scanout.
    always_ff @(posedge clock) begin
        if (w_wr_top) begin
            if (wr_mask[2]) r_top_r[w_wr_word] <= wr_data[21:16];
            if (wr_mask[1]) r_top_g[w_wr_word] <= wr_data[13:8];
            if (wr_mask[0]) r_top_b[w_wr_word] <= wr_data[5:0];
        end
        if (w_wr_bot) begin
            if (wr_mask[2]) r_bot_r[w_wr_word] <= wr_data[21:16];
            if (wr_mask[1]) r_bot_g[w_wr_word] <= wr_data[13:8];
            if (wr_mask[0]) r_bot_b[w_wr_word] <= wr_data[5:0];
        end
    end

    // Registered read of both banks at the same word; a same-cycle write to
    // that word is seen on the following read.
    always_ff @(posedge clock) begin
        if (reset) begin
            hub_r1 <= 1'b0;
            hub_g1 <= 1'b0;
            hub_b1 <= 1'b0;
            hub_r2 <= 1'b0;
            hub_g2 <= 1'b0;
            hub_b2 <= 1'b0;
        end else begin
            hub_r1 <= r_top_r[w_rd_addr][r_plane];
            hub_g1 <= r_top_g[w_rd_addr][r_plane];
            hub_b1 <= r_top_b[w_rd_addr][r_plane];
            hub_r2 <= r_bot_r[w_rd_addr][r_plane];
            hub_g2 <= r_bot_g[w_rd_addr][r_plane];
            hub_b2 <= r_bot_b[w_rd_addr][r_plane];
        end
    end

    // r_state/r_cnt name the position whose outputs are produced at the next
    // edge; the outputs therefore describe the position just left behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_SHIFT;
            r_cnt       <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            hub_a       <= '0;
            hub_clk     <= 1'b0;
            hub_lat     <= 1'b0;
            hub_oe_n    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hub_clk     <= 1'b0;
            hub_lat     <= 1'b0;
            hub_oe_n    <= 1'b1;
            frame_start <= 1'b0;
            case (r_state)
                S_SHIFT: begin
                    hub_clk     <= w_clk_pos;
                    frame_start <= (r_cnt == '0) && (r_row == '0) && (r_plane == '0);
                    if (r_cnt == CW'(SHIFT_LAST)) begin
                        r_cnt   <= '0;
                        r_state <= S_BLANK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_BLANK: begin
                    hub_a   <= r_row;
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    hub_lat <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    hub_oe_n <= 1'b0;
                    if (r_cnt == w_disp_last) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        if (r_plane == 3'd5) begin
                            r_plane <= '0;
                            r_row   <= r_row + 5'd1;
                        end else begin
                            r_plane <= r_plane + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_SHIFT;
            endcase
        end
    end

endmodule
